input_conditioner: RTL and testbench
====================================

# input_conditioner

Multi-channel input conditioner: per-channel N-stage synchronizer, then a programmable glitch filter, then registered rise/fall edge pulses. It is the parametrised successor of the team's single-bit two-flop enable-gated synchronizer. It sits between asynchronous chip pins (buttons, external strobes, slow serial lines) and the core logic. Downstream blocks consume clean levels and single-cycle edge events and need no synchronizing logic of their own.

## Interface
Parameters:
- WIDTH, 4 — number of independent channels (≥1)
- STAGES, 2 — synchronizer flop stages per channel (≥2)
- FILT_BITS, 4 — width of the filter length field and of each per-channel counter (≥1)
- RST_VAL, {WIDTH{1'b0}} — per-channel reset level of the synchronizer chain and of data_out

Ports:
- clk  in  1  single clock; all state is updated on posedge
- rstb  in  1  synchronous, active-low reset, sampled on posedge clk
- en  in  1  clock enable for all channels
- filt_len  in  FILT_BITS  filter length L; a change is accepted after L+1 consecutive differing enabled cycles
- data_in  in  WIDTH  asynchronous inputs
- data_sync  out  WIDTH  raw output of the last synchronizer stage, unfiltered
- data_out  out  WIDTH  filtered, registered level
- rise  out  WIDTH  one-cycle pulse when data_out goes 0→1
- fall  out  WIDTH  one-cycle pulse when data_out goes 1→0

## Operation
- Reset (rstb=0 at posedge, overrides en):
  - every synchronizer stage and data_out = RST_VAL
  - every counter = 0
  - rise = fall = 0
- en=0: all state holds. rise and fall are driven 0 on that edge, so a pulse is never stretched.
- Synchronizer (en=1): stage0 ← data_in, stage k ← stage k-1. data_sync = stage STAGES-1.
- Filter (en=1), per channel i with s = data_sync[i] and cnt_i:
  - s == data_out[i]: cnt_i ← 0. No event.
  - s != data_out[i] and cnt_i ≥ filt_len: data_out[i] ← s, cnt_i ← 0, rise[i] ← s, fall[i] ← ~s.
  - s != data_out[i] and cnt_i < filt_len: cnt_i ← cnt_i+1.
- The ≥ comparison means that lowering filt_len mid-count accepts the change on the next differing enabled cycle.
- cnt_i never exceeds 2^FILT_BITS−1, so the counter cannot wrap.
- filt_len=0: data_out follows data_sync with one enabled cycle of lag. Every toggle of data_sync produces an edge pulse.
- Channels are fully independent. Simultaneous events on several channels are each reported in the same cycle.
- rise and fall are mutually exclusive per channel. Both are 0 on any edge with no accepted change.

## Timing
- Latency, data_in step to data_out and edge pulse: STAGES + filt_len + 1 enabled posedges. Measured from the first posedge that samples the new value into stage0, counted as edge 1.
- data_sync changes STAGES enabled edges after the step.
- rise/fall are registered and assert in the same cycle data_out changes. They are high for exactly one clk cycle.
- Glitch rejection: after synchronization, a pulse lasting ≤ filt_len enabled cycles produces no data_out change and no pulse. The counter returns to 0 when data_sync returns to the data_out level.
- Disabled cycles neither advance nor clear a count. A count spanning en=0 gaps still needs L+1 enabled differing cycles.
- Reset mid-count (cnt > 0) discards the count. Any pending change is lost. Outputs show RST_VAL with no pulse on the reset edge or the following edge.
- Metastability: stage0 is the only flop that samples data_in. No combinational path exists from data_in to any output.

## Test plan
- Reset values: WIDTH=4, RST_VAL=4'b1010. Hold rstb=0 for 2 edges → data_sync=data_out=4'b1010, rise=fall=0. Release with data_in=4'b1010 → no pulses.
- Minimum latency: STAGES=2, filt_len=0, en=1. data_in[0] 0→1 → data_sync[0]=1 after edge 2, data_out[0]=1 and rise[0]=1 after edge 3, rise[0]=0 after edge 4.
- Glitch rejection: filt_len=3. Hold data_in[1] at 1 for 3 cycles → no change on data_out[1]. Hold it for 4 cycles → data_out[1]=1 at edge 2+4, single rise[1].
- Enable gating: filt_len=2. Mid-count, drop en for 5 cycles → state frozen, rise/fall=0. Re-enable → change accepted after the remaining enabled cycles, total 3 differing enabled cycles.
- Reset mid-count: filt_len=7, cnt=5 on channel 2, assert rstb=0 for 1 edge → data_out[2]=RST_VAL[2], no fall/rise pulse. The count restarts from 0 after release.
- Multi-channel plus filt_len change: toggle channels 0 and 3 simultaneously 1→0 with filt_len=5. At cnt=3, lower filt_len to 1 → both data_out bits fall on the next enabled edge, with fall=4'b1001 in that single cycle.

Source files
------------

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: N-stage synchronizer, programmable glitch filter and
// registered rise/fall edge pulses, all gated by a common clock enable.
module input_conditioner #(
  parameter int unsigned      WIDTH     = 4,
  parameter int unsigned      STAGES    = 2,
  parameter int unsigned      FILT_BITS = 4,
  parameter logic [WIDTH-1:0] RST_VAL   = {WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 en,
  input  logic [FILT_BITS-1:0] filt_len,
  input  logic [WIDTH-1:0]     data_in,
  output logic [WIDTH-1:0]     data_sync,
  output logic [WIDTH-1:0]     data_out,
  output logic [WIDTH-1:0]     rise,
  output logic [WIDTH-1:0]     fall
);

  logic [WIDTH-1:0]     sync_q [STAGES];
  logic [FILT_BITS-1:0] cnt_q  [WIDTH];
  logic [FILT_BITS-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0]     out_q, out_d;
  logic [WIDTH-1:0]     rise_q, rise_d;
  logic [WIDTH-1:0]     fall_q, fall_d;
  logic [WIDTH-1:0]     sync_last;

  assign sync_last = sync_q[STAGES-1];

  // cnt_q counts prior consecutive differing cycles, so a change needs filt_len+1 of them.
  always_comb begin
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_last[i] == out_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= filt_len) begin
        out_d[i]  = sync_last[i];
        cnt_d[i]  = '0;
        rise_d[i] = sync_last[i];
        fall_d[i] = ~sync_last[i];
      end else begin
        cnt_d[i] = cnt_q[i] + FILT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        sync_q[k] <= RST_VAL;
      end
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
      out_q  <= RST_VAL;
      rise_q <= '0;
      fall_q <= '0;
    end else if (en) begin
      sync_q[0] <= data_in;
      for (int k = 1; k < int'(STAGES); k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end else begin
      // Pulses last exactly one clock even when the next cycle is disabled.
      rise_q <= '0;
      fall_q <= '0;
    end
  end

  assign data_sync = sync_last;
  assign data_out  = out_q;
  assign rise      = rise_q;
  assign fall      = fall_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: a queue-based reference model predicts each cycle's
// outputs at stimulus time; an independent monitor compares them after every clock edge.
module tb_input_conditioner;

  localparam int unsigned W  = 4;
  localparam int unsigned ST = 2;
  localparam int unsigned FB = 4;
  localparam logic [W-1:0] RV = 4'b1010;

  logic          clk;
  logic          rstb;
  logic          en;
  logic [FB-1:0] filt_len;
  logic [W-1:0]  data_in;
  logic [W-1:0]  data_sync;
  logic [W-1:0]  data_out;
  logic [W-1:0]  rise;
  logic [W-1:0]  fall;

  input_conditioner #(
    .WIDTH    (W),
    .STAGES   (ST),
    .FILT_BITS(FB),
    .RST_VAL  (RV)
  ) dut (
    .clk      (clk),
    .rstb     (rstb),
    .en       (en),
    .filt_len (filt_len),
    .data_in  (data_in),
    .data_sync(data_sync),
    .data_out (data_out),
    .rise     (rise),
    .fall     (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] sync;
    logic [W-1:0] out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] in_line[$];  // delay line: element 0 is what data_sync shows
  logic [W-1:0] s_hist[$];   // filter inputs seen on enabled edges since reset
  logic [W-1:0] out_m;
  int           errors = 0;
  int           checks = 0;
  logic         stim_done = 1'b0;

  // One clock of stimulus; predicts the outputs that follow the next posedge.
  task automatic drive(input logic r, input logic e, input logic [FB-1:0] fl,
                       input logic [W-1:0] din);
    exp_t         x;
    logic [W-1:0] s;
    logic [W-1:0] nxt;
    int           run;
    @(negedge clk);
    rstb     = r;
    en       = e;
    filt_len = fl;
    data_in  = din;
    x.rise   = '0;
    x.fall   = '0;
    if (!r) begin
      in_line.delete();
      for (int k = 0; k < int'(ST); k++) in_line.push_back(RV);
      s_hist.delete();
      out_m = RV;
    end else if (e) begin
      s = in_line[0];
      void'(in_line.pop_front());
      in_line.push_back(din);
      s_hist.push_back(s);
      if (s_hist.size() > 20) void'(s_hist.pop_front());
      nxt = out_m;
      for (int i = 0; i < int'(W); i++) begin
        // Length of the most recent run of samples that disagree with the output level.
        run = 0;
        for (int j = s_hist.size() - 1; j >= 0; j--) begin
          if (s_hist[j][i] == out_m[i]) break;
          run++;
        end
        if (run >= int'(fl) + 1) begin
          nxt[i]    = s[i];
          x.rise[i] = s[i];
          x.fall[i] = ~s[i];
        end
      end
      out_m = nxt;
    end
    x.sync = in_line[0];
    x.out  = out_m;
    exp_q.push_back(x);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
    end
  endtask

  // Monitor: every posedge that had stimulus issued before it produces one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("data_sync", data_sync, e.sync);
        check("data_out", data_out, e.out);
        check("rise", rise, e.rise);
        check("fall", fall, e.fall);
      end
    end
  end

  initial begin
    logic [W-1:0]  din;
    logic [FB-1:0] fl;
    logic          r;
    logic          e;
    rstb     = 1'b0;
    en       = 1'b0;
    filt_len = '0;
    data_in  = RV;

    // Reset state and clean release.
    repeat (2) drive(1'b0, 1'b1, 4'd0, RV);
    repeat (4) drive(1'b1, 1'b1, 4'd0, RV);

    // Minimum latency with filt_len=0 on channel 0.
    repeat (5) drive(1'b1, 1'b1, 4'd0, 4'b1011);

    // Glitch of 3 cycles rejected, 4 cycles accepted, on channel 2 with filt_len=3.
    repeat (3) drive(1'b1, 1'b1, 4'd3, 4'b1111);
    repeat (8) drive(1'b1, 1'b1, 4'd3, 4'b1011);
    repeat (4) drive(1'b1, 1'b1, 4'd3, 4'b1111);
    repeat (8) drive(1'b1, 1'b1, 4'd3, 4'b1111);

    // Enable gap in the middle of a count, filt_len=2.
    repeat (3) drive(1'b1, 1'b1, 4'd2, 4'b1110);
    repeat (5) drive(1'b1, 1'b0, 4'd2, 4'b1110);
    repeat (4) drive(1'b1, 1'b1, 4'd2, 4'b1110);

    // Reset mid-count on channel 2, filt_len=7.
    repeat (7) drive(1'b1, 1'b1, 4'd7, 4'b1010);
    drive(1'b0, 1'b1, 4'd7, 4'b1010);
    repeat (12) drive(1'b1, 1'b1, 4'd7, 4'b1110);

    // Channels 0 and 3 fall together; filt_len lowered from 5 to 1 mid-count.
    repeat (6) drive(1'b1, 1'b1, 4'd0, 4'b1111);
    repeat (5) drive(1'b1, 1'b1, 4'd5, 4'b0110);
    repeat (4) drive(1'b1, 1'b1, 4'd1, 4'b0110);

    // Randomized traffic: slowly changing inputs, sparse disables and resets.
    din = 4'b0110;
    fl  = 4'd2;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < int'(W); i++) begin
        if ($urandom_range(0, 5) == 0) din[i] = ~din[i];
      end
      if ($urandom_range(0, 49) == 0) fl = FB'($urandom_range(0, 15));
      else if ($urandom_range(0, 99) == 0) fl = FB'($urandom_range(0, 3));
      r = ($urandom_range(0, 299) != 0);
      e = ($urandom_range(0, 7) != 0);
      drive(r, e, fl, din);
    end
    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
